// File: rtl/router_port_rx_pkg.sv
// Shared types and constants for the router input-port receiver.
package router_port_rx_pkg;

  localparam int ADDR_BITS = 3;
  localparam int BYTE_BITS = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ADDR     = 2'd1,
    DATA     = 2'd2,
    WAIT_LOW = 2'd3
  } rx_state_t;

  typedef struct packed {
    logic [2:0] addr;
    logic [7:0] data;
    logic       last;
  } rx_entry_t;

endpackage

// File: rtl/router_rx_fifo.sv
// Small entry FIFO; the head entry is read straight from the storage registers.
module router_rx_fifo
  import router_port_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  rx_entry_t wdata,
  input  logic      pop,
  output rx_entry_t rdata,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  rx_entry_t   mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  // Extra MSB on each pointer distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/router_port_rx.sv
// Per-port serial receiver: frame detect, address/byte deserialize, entry buffering.
//   state    | meaning
//   IDLE     | waiting for a rising edge of valid
//   ADDR     | shifting in the 3 destination address bits
//   DATA     | shifting in payload bits, one byte per 8 cycles
//   WAIT_LOW | out of reset; ignore any frame in flight until valid drops
module router_port_rx
  import router_port_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid,
  input  logic       stream,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_addr,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       busy,
  output logic       err_partial,
  output logic       err_overflow
);

  localparam logic [2:0] ADDR_LAST = 3'(ADDR_BITS - 1);
  localparam logic [2:0] BYTE_LAST = 3'(BYTE_BITS - 1);

  rx_state_t  state, state_nx;
  logic       valid_q;
  logic [2:0] bit_cnt, bit_cnt_nx;
  logic [2:0] addr_sr, addr_nx;
  logic [7:0] byte_sr, byte_nx;
  logic       pend_vld, pend_vld_nx;
  logic [2:0] pend_addr, pend_addr_nx;
  logic [7:0] pend_data, pend_data_nx;
  logic       set_partial;

  logic       pop, drop, fifo_push, full, empty;
  rx_entry_t  wentry, rentry;

  always_comb begin
    state_nx     = state;
    bit_cnt_nx   = bit_cnt;
    addr_nx      = addr_sr;
    byte_nx      = byte_sr;
    pend_vld_nx  = 1'b0;
    pend_addr_nx = pend_addr;
    pend_data_nx = pend_data;
    set_partial  = 1'b0;
    case (state)
      IDLE: begin
        if (valid && !valid_q) begin
          state_nx   = ADDR;
          bit_cnt_nx = '0;
        end
      end
      ADDR: begin
        if (!valid) begin
          state_nx    = IDLE;
          set_partial = 1'b1;
        end else begin
          addr_nx = {addr_sr[1:0], stream};
          if (bit_cnt == ADDR_LAST) begin
            state_nx   = DATA;
            bit_cnt_nx = '0;
          end else begin
            bit_cnt_nx = bit_cnt + 3'd1;
          end
        end
      end
      DATA: begin
        if (!valid) begin
          state_nx = IDLE;
          if (bit_cnt != '0) set_partial = 1'b1;
        end else begin
          byte_nx = {byte_sr[6:0], stream};
          if (bit_cnt == BYTE_LAST) begin
            // Hold the byte one cycle so valid in the next cycle decides last.
            pend_vld_nx  = 1'b1;
            pend_addr_nx = addr_sr;
            pend_data_nx = byte_nx;
            bit_cnt_nx   = '0;
          end else begin
            bit_cnt_nx = bit_cnt + 3'd1;
          end
        end
      end
      WAIT_LOW: begin
        if (!valid) state_nx = IDLE;
      end
      default: state_nx = WAIT_LOW;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= WAIT_LOW;
      valid_q      <= 1'b0;
      bit_cnt      <= '0;
      addr_sr      <= '0;
      byte_sr      <= '0;
      pend_vld     <= 1'b0;
      pend_addr    <= '0;
      pend_data    <= '0;
      err_partial  <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      state        <= state_nx;
      valid_q      <= valid;
      bit_cnt      <= bit_cnt_nx;
      addr_sr      <= addr_nx;
      byte_sr      <= byte_nx;
      pend_vld     <= pend_vld_nx;
      pend_addr    <= pend_addr_nx;
      pend_data    <= pend_data_nx;
      err_partial  <= err_partial | set_partial;
      err_overflow <= err_overflow | drop;
    end
  end

  assign pop       = out_valid && out_ready;
  assign drop      = pend_vld && full && !pop;
  assign fifo_push = pend_vld && !drop;
  assign wentry    = '{addr: pend_addr, data: pend_data, last: !valid};

  router_rx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata (wentry),
    .pop   (pop),
    .rdata (rentry),
    .full  (full),
    .empty (empty)
  );

  assign out_valid = !empty;
  assign out_addr  = rentry.addr;
  assign out_data  = rentry.data;
  assign out_last  = rentry.last;
  assign busy      = (state == ADDR) || (state == DATA);

endmodule

// File: tb/tb_router_port_rx.sv
// Bench for router_port_rx: packets are laid out as cycle schedules and the expected
// entry stream is derived from frame arithmetic, then run through a queue-level FIFO model.
module tb_router_port_rx;

  localparam int DEPTH = 4;
  localparam int N     = 4096;

  logic       clk, reset, valid, stream, out_ready;
  logic       out_valid, out_last, busy, err_partial, err_overflow;
  logic [2:0] out_addr;
  logic [7:0] out_data;

  router_port_rx #(.FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .valid        (valid),
    .stream       (stream),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_addr     (out_addr),
    .out_data     (out_data),
    .out_last     (out_last),
    .busy         (busy),
    .err_partial  (err_partial),
    .err_overflow (err_overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Cycle schedule
  logic        sv_valid  [N];
  logic        sv_stream [N];
  logic        busy_exp  [N];
  logic        part_at   [N];
  logic        push_at   [N];
  logic [11:0] push_ent  [N];
  int          len;
  int          rdy_pct;

  // Reference state: entries the FIFO should hold, plus sticky flags
  logic [11:0] exp_q[$];
  logic        exp_part, exp_ovf;
  int          n_taken;

  task automatic clear_sched();
    for (int i = 0; i < N; i++) begin
      sv_valid[i] = 1'b0; sv_stream[i] = 1'b0; busy_exp[i] = 1'b0;
      part_at[i]  = 1'b0; push_at[i]   = 1'b0; push_ent[i] = '0;
    end
    len = 0;
  endtask

  task automatic add_idle(input int n, input logic v);
    for (int i = 0; i < n; i++) begin
      sv_valid[len]  = v;
      sv_stream[len] = 1'($urandom);
      busy_exp[len]  = 1'b0;
      len++;
    end
  endtask

  // Start cycle, na address bits, nbits payload bits, then one low cycle.
  task automatic add_packet(input int na, input logic [2:0] a, input int nbits,
                            input logic [7:0] pay[$]);
    int s, e, nb;
    logic [7:0] d;
    logic [7:0] pb;
    logic       lst;
    s = len;
    sv_valid[s] = 1'b1; sv_stream[s] = 1'($urandom); busy_exp[s] = 1'b0;
    for (int i = 0; i < na; i++) begin
      sv_valid[s+1+i]  = 1'b1;
      sv_stream[s+1+i] = (na == 3) ? a[2-i] : 1'($urandom);
      busy_exp[s+1+i]  = 1'b1;
    end
    if (na < 3) begin
      e = s + 1 + na;
      part_at[e] = 1'b1;
    end else begin
      for (int i = 0; i < nbits; i++) begin
        sv_valid[s+4+i] = 1'b1;
        busy_exp[s+4+i] = 1'b1;
        if (i / 8 < pay.size()) begin
          pb = pay[i/8];
          sv_stream[s+4+i] = pb[7 - (i % 8)];
        end else begin
          sv_stream[s+4+i] = 1'($urandom);
        end
      end
      e  = s + 4 + nbits;
      nb = nbits / 8;
      if (nbits % 8 != 0) part_at[e] = 1'b1;
      for (int j = 0; j < nb; j++) begin
        d = '0;
        for (int b = 0; b < 8; b++) d = {d[6:0], sv_stream[s+4+8*j+b]};
        // A byte followed by more bits is never marked last, even if those bits are later discarded.
        lst = (j == nb - 1) && (nbits % 8 == 0);
        push_at[s+12+8*j]  = 1'b1;
        push_ent[s+12+8*j] = {a, d, lst};
      end
    end
    sv_valid[e] = 1'b0; sv_stream[e] = 1'($urandom); busy_exp[e] = 1'b1;
    len = e + 1;
  endtask

  task automatic reset_model();
    exp_q.delete();
    exp_part = 1'b0;
    exp_ovf  = 1'b0;
  endtask

  task automatic run_sched();
    logic [11:0] ent;
    logic        pop, was_full;
    for (int t = 0; t < len; t++) begin
      @(negedge clk);
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0 && out_valid) begin
        ent = exp_q[0];
        chk("out_addr", 32'(out_addr), 32'(ent[11:9]));
        chk("out_data", 32'(out_data), 32'(ent[8:1]));
        chk("out_last", 32'(out_last), 32'(ent[0]));
      end
      chk("busy", 32'(busy), 32'(busy_exp[t]));
      chk("err_partial", 32'(err_partial), 32'(exp_part));
      chk("err_overflow", 32'(err_overflow), 32'(exp_ovf));
      valid     = sv_valid[t];
      stream    = sv_stream[t];
      out_ready = ($urandom_range(99) < rdy_pct);
      if (out_valid && out_ready) n_taken++;
      was_full = (exp_q.size() == DEPTH);
      pop      = (exp_q.size() != 0) && out_ready;
      if (pop) void'(exp_q.pop_front());
      if (push_at[t]) begin
        if (was_full && !pop) exp_ovf = 1'b1;
        else exp_q.push_back(push_ent[t]);
      end
      if (part_at[t]) exp_part = 1'b1;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_addr"},  32'(out_addr),  32'd0);
    chk({tag, "_out_data"},  32'(out_data),  32'd0);
    chk({tag, "_out_last"},  32'(out_last),  32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_err_part"},  32'(err_partial),  32'd0);
    chk({tag, "_err_ovf"},   32'(err_overflow), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_reset_outputs("reset");
    reset_model();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  logic [7:0] pay[$];

  initial begin
    reset = 1'b1; valid = 1'b0; stream = 1'b0; out_ready = 1'b0;
    rdy_pct = 100;
    n_taken = 0;
    reset_model();
    clear_sched();
    repeat (3) @(negedge clk);
    chk_reset_outputs("init");
    reset = 1'b0;

    // 1: single byte to addr 5
    clear_sched();
    add_idle(2, 1'b0);
    pay = '{8'hA5};
    add_packet(3, 3'b101, 8, pay);
    add_idle(4, 1'b0);
    run_sched();

    // 2: three bytes with a ready consumer
    clear_sched();
    pay = '{8'hA5, 8'h3C, 8'hFF};
    add_packet(3, 3'b010, 24, pay);
    add_idle(4, 1'b0);
    run_sched();

    // 3: consumer stalled through a 6-byte packet, then drains
    do_reset();
    rdy_pct = 0;
    clear_sched();
    add_idle(1, 1'b0);
    pay = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    add_packet(3, 3'b110, 48, pay);
    add_idle(2, 1'b0);
    run_sched();
    rdy_pct = 100;
    n_taken = 0;
    clear_sched();
    add_idle(8, 1'b0);
    run_sched();
    chk("t3_delivered", 32'(n_taken), 32'd4);

    // 4: aborted address, then a packet with a trailing partial byte
    do_reset();
    clear_sched();
    add_idle(1, 1'b0);
    pay = '{};
    add_packet(2, 3'b000, 0, pay);
    pay = '{8'hC3};
    add_packet(3, 3'b011, 12, pay);
    add_idle(4, 1'b0);
    run_sched();

    // 5: back-to-back packets with a single low cycle between them
    do_reset();
    clear_sched();
    add_idle(1, 1'b0);
    pay = '{8'h81};
    add_packet(3, 3'b111, 8, pay);
    pay = '{8'h18};
    add_packet(3, 3'b000, 8, pay);
    add_idle(4, 1'b0);
    run_sched();

    // 6: reset while a packet is in DATA with valid held high
    do_reset();
    clear_sched();
    add_idle(1, 1'b0);
    pay = '{8'hF0};
    add_packet(3, 3'b001, 8, pay);
    len = 1 + 4 + 5;
    run_sched();
    do_reset();
    clear_sched();
    add_idle(6, 1'b1);
    add_idle(1, 1'b0);
    pay = '{8'h5A, 8'h96};
    add_packet(3, 3'b100, 16, pay);
    add_idle(4, 1'b0);
    run_sched();

    // Random packets, mixed lengths, gaps and consumer back-pressure
    for (int r = 0; r < 12; r++) begin
      if (r % 4 == 0) do_reset();
      rdy_pct = 30 + $urandom_range(70);
      clear_sched();
      add_idle(1, 1'b0);
      for (int p = 0; p < 8; p++) begin
        int na, nbits;
        na    = ($urandom_range(9) == 0) ? $urandom_range(2) : 3;
        nbits = ($urandom_range(1) == 0) ? 8 * $urandom_range(4) : $urandom_range(40);
        pay = '{};
        add_packet(na, 3'($urandom), nbits, pay);
        add_idle($urandom_range(3), 1'b0);
      end
      rdy_pct = (rdy_pct < 50) ? rdy_pct : 100;
      add_idle(12, 1'b0);
      run_sched();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
